// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit -- load-use and mult/div interlocks, branch flush, stall counter
// Ports: clk, reset (async, active-low); ID_rs/ID_rt/ID_UseRs/ID_UseRt describe the ID reads;
// EX_MemRead/EX_WriteReg describe a load in EX; EX_BranchTaken requests a flush;
// ID_MDStart/ID_MDUse describe mult/div issue and HI/LO use; outputs PC_Write, IFID_Write,
// IFID_Flush, ID_Stall gate the front end, MD_Busy marks the mult/div unit occupied,
// StallCnt counts hazard-stall cycles and saturates.
module hazard_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UseRs,
   input  logic             ID_UseRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             EX_BranchTaken,
   input  logic             ID_MDStart,
   input  logic             ID_MDUse,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             ID_Stall,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] StallCnt
);
   localparam int MW = $clog2(MD_CYCLES + 1);
   typedef enum logic {RUN, MD_WAIT} state_t;
   state_t state, state_nx;
   logic [MW-1:0] md_cnt, md_cnt_nx;
   logic lu, mh, hz, start;
   // $zero is never a real dependency, so a load targeting r0 cannot stall
   assign lu = EX_MemRead && EX_WriteReg != 5'd0 &&
               ((ID_UseRs && ID_rs == EX_WriteReg) || (ID_UseRt && ID_rt == EX_WriteReg));
   assign mh = state == MD_WAIT && ID_MDUse;
   // a taken branch kills the ID instruction, so its hazards are moot
   assign hz = (lu || mh) && !EX_BranchTaken;
   assign start = ID_MDStart && !EX_BranchTaken && !lu && !mh;
   assign PC_Write   = !hz;
   assign IFID_Write = !hz;
   assign IFID_Flush = EX_BranchTaken;
   assign ID_Stall   = EX_BranchTaken || hz;
   assign MD_Busy    = state == MD_WAIT;
   // an issued operation always runs to completion; flushes and stalls do not touch the countdown
   always_comb begin
      state_nx  = state;
      md_cnt_nx = md_cnt;
      if (state == RUN) begin
         state_nx  = start ? MD_WAIT : RUN;
         md_cnt_nx = start ? MW'(MD_CYCLES - 1) : md_cnt;
      end else begin
         state_nx  = md_cnt == '0 ? RUN : MD_WAIT;
         md_cnt_nx = md_cnt == '0 ? '0 : md_cnt - MW'(1);
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         md_cnt   <= '0;
         StallCnt <= '0;
      end else begin
         state    <= state_nx;
         md_cnt   <= md_cnt_nx;
         if (hz && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MD_CYCLES=4, CNT_W=4)
module tb_hazard_ctrl;
   logic clk = 1'b0, reset;
   logic [4:0] ID_rs, ID_rt, EX_WriteReg;
   logic ID_UseRs, ID_UseRt, EX_MemRead, EX_BranchTaken, ID_MDStart, ID_MDUse;
   logic PC_Write, IFID_Write, IFID_Flush, ID_Stall, MD_Busy;
   logic [3:0] StallCnt, ctl;
   int n_cmp = 0, n_err = 0;
   localparam logic [3:0] C_RUN = 4'b1100, C_STALL = 4'b0010, C_FLUSH = 4'b1111;

   hazard_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
      .ID_UseRt(ID_UseRt), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .EX_BranchTaken(EX_BranchTaken), .ID_MDStart(ID_MDStart), .ID_MDUse(ID_MDUse),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .ID_Stall(ID_Stall), .MD_Busy(MD_Busy), .StallCnt(StallCnt)
   );

   always #5 clk = ~clk;
   assign ctl = {PC_Write, IFID_Write, ID_Stall, IFID_Flush};

   task automatic idle();
      ID_rs = 0; ID_rt = 0; EX_WriteReg = 0; ID_UseRs = 0; ID_UseRt = 0;
      EX_MemRead = 0; EX_BranchTaken = 0; ID_MDStart = 0; ID_MDUse = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [4:0] r);
      EX_MemRead = 1; EX_WriteReg = r; ID_rs = r; ID_UseRs = 1;
   endtask

   task automatic test_reset();
      idle();
      reset = 0;
      tick();
      #2;
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_RUN); end
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", MD_Busy); end
      n_cmp++; if (StallCnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", StallCnt); end
      tick();
      reset = 1;
      tick();
   endtask

   task automatic test_load_use();
      set_lu(5'd8);
      #2;
      n_cmp++; if (ctl !== C_STALL) begin n_err++; $display("FAIL lu_rs_ctl got %b want %b", ctl, C_STALL); end
      n_cmp++; if (StallCnt !== 4'd0) begin n_err++; $display("FAIL lu_cnt_before got %0d want 0", StallCnt); end
      tick();
      idle();
      #2;
      n_cmp++; if (StallCnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt_after got %0d want 1", StallCnt); end
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL lu_release got %b want %b", ctl, C_RUN); end
      EX_MemRead = 1; EX_WriteReg = 9; ID_rt = 9; ID_UseRt = 1;
      #2;
      n_cmp++; if (ctl !== C_STALL) begin n_err++; $display("FAIL lu_rt_ctl got %b want %b", ctl, C_STALL); end
      tick();
      idle();
      EX_MemRead = 1; EX_WriteReg = 8; ID_rs = 8; ID_UseRs = 0;
      #2;
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL lu_unused_rs got %b want %b", ctl, C_RUN); end
      tick();
      idle();
      #2;
      n_cmp++; if (StallCnt !== 4'd2) begin n_err++; $display("FAIL lu_cnt2 got %0d want 2", StallCnt); end
   endtask

   task automatic test_zero_flush();
      set_lu(5'd0);
      #2;
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL zero_reg got %b want %b", ctl, C_RUN); end
      tick();
      idle();
      set_lu(5'd5);
      EX_BranchTaken = 1;
      #2;
      n_cmp++; if (ctl !== C_FLUSH) begin n_err++; $display("FAIL flush_ctl got %b want %b", ctl, C_FLUSH); end
      tick();
      idle();
      #2;
      n_cmp++; if (StallCnt !== 4'd2) begin n_err++; $display("FAIL flush_cnt got %0d want 2", StallCnt); end
   endtask

   task automatic test_md();
      ID_MDStart = 1; ID_MDUse = 1;
      #2;
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL md_issue_ctl got %b want %b", ctl, C_RUN); end
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL md_issue_busy got %b want 0", MD_Busy); end
      tick();
      ID_MDStart = 0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 1) set_lu(5'd4);
         #2;
         n_cmp++; if (MD_Busy !== 1'b1) begin n_err++; $display("FAIL md_busy_t%0d got %b want 1", i, MD_Busy); end
         n_cmp++; if (ctl !== C_STALL) begin n_err++; $display("FAIL md_stall_t%0d got %b want %b", i, ctl, C_STALL); end
         tick();
         EX_MemRead = 0; ID_UseRs = 0;
      end
      #2;
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL md_done_busy got %b want 0", MD_Busy); end
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL md_done_ctl got %b want %b", ctl, C_RUN); end
      n_cmp++; if (StallCnt !== 4'd6) begin n_err++; $display("FAIL md_cnt got %0d want 6", StallCnt); end
      idle();
      tick();
   endtask

   task automatic test_discard();
      ID_MDStart = 1; ID_MDUse = 1; EX_BranchTaken = 1;
      #2;
      n_cmp++; if (ctl !== C_FLUSH) begin n_err++; $display("FAIL disc_br_ctl got %b want %b", ctl, C_FLUSH); end
      tick();
      idle();
      #2;
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL disc_br_busy got %b want 0", MD_Busy); end
      ID_MDStart = 1; ID_MDUse = 1; set_lu(5'd3);
      tick();
      idle();
      #2;
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL disc_lu_busy got %b want 0", MD_Busy); end
      n_cmp++; if (StallCnt !== 4'd7) begin n_err++; $display("FAIL disc_lu_cnt got %0d want 7", StallCnt); end
   endtask

   task automatic test_reset_mid();
      ID_MDStart = 1;
      tick();
      idle();
      tick();
      #2;
      n_cmp++; if (MD_Busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got %b want 1", MD_Busy); end
      reset = 0;
      #1;
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", MD_Busy); end
      n_cmp++; if (StallCnt !== 4'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", StallCnt); end
      n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL rst_mid_ctl got %b want %b", ctl, C_RUN); end
      tick();
      reset = 1;
      tick();
      #2;
      n_cmp++; if (MD_Busy !== 1'b0) begin n_err++; $display("FAIL rst_after_busy got %b want 0", MD_Busy); end
   endtask

   task automatic test_saturation();
      set_lu(5'd7);
      for (int i = 1; i <= 20; i++) begin
         tick();
         #2;
         if (i == 14) begin
            n_cmp++; if (StallCnt !== 4'd14) begin n_err++; $display("FAIL sat_14 got %0d want 14", StallCnt); end
         end
      end
      n_cmp++; if (StallCnt !== 4'd15) begin n_err++; $display("FAIL sat_20 got %0d want 15", StallCnt); end
      idle();
      tick();
      #2;
      n_cmp++; if (StallCnt !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d want 15", StallCnt); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_flush();
      test_md();
      test_discard();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32, giving the multiply/divide latency in cycles (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports ID_rs and ID_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-006 SHALL have ports ID_UseRs and ID_UseRt, input, 1 bit each: the ID instruction actually reads rs or rt.
REQ-007 SHALL have port EX_MemRead, input, 1 bit: the load-class instruction is in EX.
REQ-008 SHALL have port EX_WriteReg, input, 5 bits: the destination register of the EX instruction.
REQ-009 SHALL have port EX_BranchTaken, input, 1 bit: branch or jump resolved taken in EX.
REQ-010 SHALL have port ID_MDStart, input, 1 bit: the ID instruction issues a mult or div.
REQ-011 SHALL have port ID_MDUse, input, 1 bit: the ID instruction reads HI/LO or issues a mult or div.
REQ-012 SHALL have ports PC_Write and IFID_Write, output, 1 bit each: enables for the PC and IF/ID registers.
REQ-013 SHALL have port IFID_Flush, output, 1 bit: clears IF/ID to a nop.
REQ-014 SHALL have port ID_Stall, output, 1 bit: inserts a bubble in ID/EX by forcing EX control writes to 0.
REQ-015 SHALL have port MD_Busy, output, 1 bit: the multiply/divide unit is occupied.
REQ-016 SHALL have port StallCnt, output, CNT_W bits: count of hazard-stall cycles.

Function
REQ-017 SHALL raise load-use hazard LU when EX_MemRead=1, EX_WriteReg!=0, and either (ID_UseRs and ID_rs==EX_WriteReg) or (ID_UseRt and ID_rt==EX_WriteReg).
REQ-018 SHALL hold an FSM with states RUN and MD_WAIT, plus a down-counter MdCnt of width ceil(log2(MD_CYCLES+1)).
REQ-019 SHALL raise MD hazard MH when state==MD_WAIT and ID_MDUse=1.
REQ-020 SHALL drive all control outputs combinationally from the inputs and the registered state, with no added latency.
REQ-021 SHALL, at flush priority (EX_BranchTaken=1), drive IFID_Flush=1, ID_Stall=1, PC_Write=1 and IFID_Write=1, and ignore LU and MH.
REQ-022 SHALL, at hazard priority (no flush, LU or MH), drive PC_Write=0, IFID_Write=0, ID_Stall=1 and IFID_Flush=0.
REQ-023 SHALL, otherwise, drive PC_Write=1, IFID_Write=1, ID_Stall=0 and IFID_Flush=0.
REQ-024 SHALL accept an MD start when ID_MDStart=1, EX_BranchTaken=0, LU=0 and MH=0; the next state is MD_WAIT with MdCnt=MD_CYCLES-1.
REQ-025 SHALL, in MD_WAIT, decrement MdCnt by 1 each cycle and move to RUN on the cycle MdCnt is 0, so MD_Busy stays high for exactly MD_CYCLES cycles after acceptance.
REQ-026 SHALL continue the MdCnt countdown in MD_WAIT regardless of EX_BranchTaken or stalls, because an issued MD operation is never cancelled.
REQ-027 SHALL discard ID_MDStart in any cycle with EX_BranchTaken=1 or a stall (no state change).
REQ-028 SHALL drive MD_Busy=1 exactly when state==MD_WAIT.
REQ-029 SHALL treat LU and MH as one hazard-stall cycle when both are true in the same cycle.
REQ-030 SHALL increment StallCnt by 1 for each hazard-stall cycle (REQ-022 condition), excluding flush cycles, and SHALL saturate StallCnt at all-ones.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state=RUN, MdCnt=0 and StallCnt=0, giving MD_Busy=0.
REQ-032 SHALL, while reset=0, present the REQ-023 values (PC_Write=1, IFID_Write=1, ID_Stall=0, IFID_Flush=0) provided EX_BranchTaken=0 and no LU is present.
REQ-033 SHALL, when reset is asserted during MD_WAIT, abandon the countdown immediately; the first cycle after release is in RUN.

Verification
REQ-034 SHALL cover load-use: EX_MemRead=1, EX_WriteReg=8, ID_rs=8, ID_UseRs=1 for one cycle -> PC_Write=0, IFID_Write=0, ID_Stall=1 that cycle, and StallCnt goes from 0 to 1.
REQ-035 SHALL cover the $zero exemption and flush priority: (a) EX_WriteReg=0 with a matching rs -> no stall; (b) EX_BranchTaken=1 together with a live LU -> IFID_Flush=1, PC_Write=1, ID_Stall=1 and StallCnt unchanged.
REQ-036 SHALL cover MD timing with MD_CYCLES=4: ID_MDStart accepted at cycle t -> MD_Busy=1 for cycles t+1..t+4 and 0 at t+5; ID_MDUse=1 held from t+1 -> stall during t+1..t+4 and released at t+5.
REQ-037 SHALL cover a discarded start: ID_MDStart=1 with EX_BranchTaken=1 -> MD_Busy stays 0.
REQ-038 SHALL cover saturation: CNT_W=4 with 20 consecutive LU cycles -> StallCnt=15 and held.
REQ-039 SHALL cover reset mid-operation: reset=0 driven two cycles into MD_WAIT -> MD_Busy=0 and StallCnt=0 immediately, independent of clk.
